// File: rtl/noc_ingress_packet_buffer_pkg.sv
// noc_ingress_packet_buffer_pkg: shared sizing helper for the ingress packet buffer.
package noc_ingress_packet_buffer_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/noc_ingress_packet_buffer_fifo.sv
// noc_ingress_fifo: single-channel flit FIFO with packet counting and oversize fallback.
//   in_flit/in_last/in_valid/in_ready     : write side from the router
//   out_flit/out_last/out_valid/out_ready : first-word fall-through read side
//   err_oversize                          : sticky, a packet overflowed DEPTH in FULLPACKET mode
module noc_ingress_fifo
    import noc_ingress_packet_buffer_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH = 16,
    parameter bit FULLPACKET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_oversize
);
    localparam int AW = clog2(DEPTH);

    logic [FLIT_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         level, pkt_cnt;
    logic                fallback, err_q, wr, rd, full, head_last, set_fb;

    assign full      = level == (AW+1)'(DEPTH);
    assign in_ready  = !full;
    assign wr        = in_valid && in_ready;
    assign rd        = out_valid && out_ready;
    assign head_last = mem[rd_ptr][FLIT_WIDTH];
    // A full buffer holding no complete packet can never drain on its own.
    assign set_fb    = FULLPACKET && full && pkt_cnt == '0;
    assign out_valid = level != '0 && (!FULLPACKET || pkt_cnt != '0 || fallback);
    assign out_flit  = out_valid ? mem[rd_ptr][FLIT_WIDTH-1:0] : '0;
    assign out_last  = out_valid && head_last;
    assign err_oversize = FULLPACKET && err_q;

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= {in_last, in_flit};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pkt_cnt  <= '0;
            fallback <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(wr);
            rd_ptr   <= rd_ptr + AW'(rd);
            level    <= level + (AW+1)'(wr) - (AW+1)'(rd);
            pkt_cnt  <= pkt_cnt + (AW+1)'(wr && in_last) - (AW+1)'(rd && head_last);
            fallback <= set_fb || (fallback && !(rd && head_last));
            err_q    <= err_q || set_fb;
        end

endmodule

// File: rtl/noc_ingress_packet_buffer.sv
// noc_ingress_packet_buffer: per-virtual-channel ingress flit buffer in front of the network adapter.
//   in_flit/in_last/in_valid/in_ready     : per-channel flits from the router
//   out_flit/out_last/out_valid/out_ready : per-channel head flits to the adapter
//   err_oversize                          : per-channel sticky oversize-packet flag
module noc_ingress_packet_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS = 2,
    parameter int DEPTH = 16,
    parameter bit FULLPACKET = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit,
    input  logic [CHANNELS-1:0]                 in_last,
    input  logic [CHANNELS-1:0]                 in_valid,
    output logic [CHANNELS-1:0]                 in_ready,
    output logic [CHANNELS-1:0][FLIT_WIDTH-1:0] out_flit,
    output logic [CHANNELS-1:0]                 out_last,
    output logic [CHANNELS-1:0]                 out_valid,
    input  logic [CHANNELS-1:0]                 out_ready,
    output logic [CHANNELS-1:0]                 err_oversize
);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        noc_ingress_fifo #(
            .FLIT_WIDTH(FLIT_WIDTH),
            .DEPTH(DEPTH),
            .FULLPACKET(FULLPACKET)
        ) u_fifo (
            .clk(clk),
            .rst(rst),
            .in_flit(in_flit[c]),
            .in_last(in_last[c]),
            .in_valid(in_valid[c]),
            .in_ready(in_ready[c]),
            .out_flit(out_flit[c]),
            .out_last(out_last[c]),
            .out_valid(out_valid[c]),
            .out_ready(out_ready[c]),
            .err_oversize(err_oversize[c])
        );
    end

endmodule

// File: tb/tb_noc_ingress_packet_buffer.sv
// tb_noc_ingress_packet_buffer: directed and random checks of packet-mode and cut-through buffers.
module tb_noc_ingress_packet_buffer;
    localparam int FW = 32, CH = 2, DEPTH = 16;

    logic clk = 1'b0, rst = 1'b1;
    logic [CH-1:0][FW-1:0] in_flit [2], out_flit [2];
    logic [CH-1:0] in_last [2], in_valid [2], in_ready [2];
    logic [CH-1:0] out_last [2], out_valid [2], out_ready [2], err_oversize [2];

    always #5 clk = ~clk;

    noc_ingress_packet_buffer #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(DEPTH), .FULLPACKET(1'b1)) dut_pkt (
        .clk(clk), .rst(rst),
        .in_flit(in_flit[0]), .in_last(in_last[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_flit(out_flit[0]), .out_last(out_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .err_oversize(err_oversize[0])
    );

    noc_ingress_packet_buffer #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(DEPTH), .FULLPACKET(1'b0)) dut_ct (
        .clk(clk), .rst(rst),
        .in_flit(in_flit[1]), .in_last(in_last[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_flit(out_flit[1]), .out_last(out_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .err_oversize(err_oversize[1])
    );

    // Reference model: queue k = instance*CH + channel; instance 0 is packet mode, 1 is cut-through.
    logic [FW:0] mq [4][$];
    logic mfb [4], merr [4];
    logic [3:0] acc;
    int total = 0, passed = 0;

    function automatic int pkts(int k);
        int n = 0;
        for (int j = 0; j < mq[k].size(); j++) n += int'(mq[k][j][FW]);
        return n;
    endfunction

    function automatic logic m_valid(int k);
        return mq[k].size() != 0 && (k >= CH || pkts(k) != 0 || mfb[k]);
    endfunction

    function automatic logic [CH-1:0] exp_ov(int i);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_valid(i*CH+c);
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_ol(int i);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_valid(i*CH+c) && mq[i*CH+c][0][FW];
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_ir(int i);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = mq[i*CH+c].size() != DEPTH;
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_err(int i);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = merr[i*CH+c];
        return r;
    endfunction

    function automatic logic [CH-1:0][FW-1:0] exp_of(int i);
        logic [CH-1:0][FW-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_valid(i*CH+c) ? mq[i*CH+c][0][FW-1:0] : '0;
        return r;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            mfb[k] = 1'b0;
            merr[k] = 1'b0;
        end
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            in_flit[i] = '0;
            in_last[i] = '0;
            in_valid[i] = '0;
            out_ready[i] = '0;
        end
    endtask

    // One clock: decide handshakes from the model, advance it at the edge, return at the falling edge.
    task automatic tick();
        logic [3:0] rd, st;
        for (int k = 0; k < 4; k++) begin
            acc[k] = in_valid[k/CH][k%CH] && mq[k].size() != DEPTH;
            rd[k] = m_valid(k) && out_ready[k/CH][k%CH];
            st[k] = k < CH && mq[k].size() == DEPTH && pkts(k) == 0;
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (rd[k]) begin
                if (mq[k][0][FW]) mfb[k] = 1'b0;
                void'(mq[k].pop_front());
            end
            if (acc[k]) mq[k].push_back({in_last[k/CH][k%CH], in_flit[k/CH][k%CH]});
            if (st[k]) begin
                mfb[k] = 1'b1;
                merr[k] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            total++; if (in_ready[i] !== 2'b11) $display("FAIL reset_in_ready[%0d] got %b expected 11", i, in_ready[i]); else passed++;
            total++; if (out_valid[i] !== 2'b00) $display("FAIL reset_out_valid[%0d] got %b expected 00", i, out_valid[i]); else passed++;
            total++; if (out_flit[i] !== '0) $display("FAIL reset_out_flit[%0d] got %h expected 0", i, out_flit[i]); else passed++;
            total++; if (out_last[i] !== 2'b00) $display("FAIL reset_out_last[%0d] got %b expected 00", i, out_last[i]); else passed++;
            total++; if (err_oversize[i] !== 2'b00) $display("FAIL reset_err[%0d] got %b expected 00", i, err_oversize[i]); else passed++;
        end
    endtask

    task automatic test_packet_basic();
        do_reset();
        out_ready[0][0] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_valid[0][0] = 1'b1;
            in_flit[0][0] = 32'hA0 + j;
            in_last[0][0] = j == 3;
            tick();
            total++; if (out_valid[0][0] !== (j == 3)) $display("FAIL pkt_hold flit%0d got %b expected %b", j, out_valid[0][0], j == 3); else passed++;
        end
        in_valid[0][0] = 1'b0;
        in_last[0][0] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            total++;
            if ({out_valid[0][0], out_last[0][0], out_flit[0][0]} !== {1'b1, j == 3, 32'hA0 + j})
                $display("FAIL pkt_deliver%0d got v%b l%b %h expected v1 l%b %h", j, out_valid[0][0], out_last[0][0], out_flit[0][0], j == 3, 32'hA0 + j);
            else passed++;
            tick();
        end
        total++; if (out_valid[0][0] !== 1'b0) $display("FAIL pkt_empty got %b expected 0", out_valid[0][0]); else passed++;
    endtask

    task automatic test_full_backpressure();
        do_reset();
        for (int j = 0; j < DEPTH; j++) begin
            in_valid[0][0] = 1'b1;
            in_last[0][0] = 1'b1;
            in_flit[0][0] = $urandom;
            total++; if (in_ready[0][0] !== 1'b1) $display("FAIL full_ready_before%0d got %b expected 1", j, in_ready[0][0]); else passed++;
            tick();
        end
        total++; if (in_ready[0][0] !== 1'b0) $display("FAIL full_ready_after16 got %b expected 0", in_ready[0][0]); else passed++;
        in_flit[0][0] = $urandom;
        out_ready[0][0] = 1'b1;
        total++; if (in_ready[0][0] !== 1'b0) $display("FAIL full_ready_during_read got %b expected 0", in_ready[0][0]); else passed++;
        tick();
        out_ready[0][0] = 1'b0;
        in_valid[0][0] = 1'b0;
        total++; if (in_ready[0][0] !== 1'b1) $display("FAIL full_ready_freed got %b expected 1", in_ready[0][0]); else passed++;
        in_valid[0][0] = 1'b1;
        tick();
        total++; if (in_ready[0][0] !== 1'b0) $display("FAIL full_refill got %b expected 0", in_ready[0][0]); else passed++;
        in_valid[0][0] = 1'b0;
        out_ready[0][0] = 1'b1;
        for (int j = 0; j < DEPTH + 1; j++) begin
            total++;
            if ({out_valid[0], out_last[0], out_flit[0]} !== {exp_ov(0), exp_ol(0), exp_of(0)})
                $display("FAIL full_drain%0d got v%b l%b %h expected v%b l%b %h", j, out_valid[0], out_last[0], out_flit[0], exp_ov(0), exp_ol(0), exp_of(0));
            else passed++;
            tick();
        end
    endtask

    task automatic test_oversize();
        logic [FW-1:0] d [20];
        int wi = 0, ri = 0, cyc = 0;
        logic ev;
        do_reset();
        for (int j = 0; j < 20; j++) d[j] = $urandom;
        for (int j = 0; j < DEPTH; j++) begin
            in_valid[0][0] = 1'b1;
            in_flit[0][0] = d[wi];
            in_last[0][0] = 1'b0;
            tick();
            if (acc[0]) wi++;
        end
        in_flit[0][0] = d[wi];
        tick();
        total++; if (err_oversize[0][0] !== 1'b1) $display("FAIL oversize_err got %b expected 1", err_oversize[0][0]); else passed++;
        total++; if (out_valid[0][0] !== 1'b1 || out_flit[0][0] !== d[0]) $display("FAIL oversize_head got v%b %h expected v1 %h", out_valid[0][0], out_flit[0][0], d[0]); else passed++;
        out_ready[0][0] = 1'b1;
        while (ri < 20 && cyc < 100) begin
            ev = m_valid(0);
            total++; if (out_valid[0][0] !== ev) $display("FAIL oversize_valid cyc%0d got %b expected %b", cyc, out_valid[0][0], ev); else passed++;
            if (ev) begin
                total++;
                if ({out_last[0][0], out_flit[0][0]} !== {ri == 19, d[ri]})
                    $display("FAIL oversize_data%0d got l%b %h expected l%b %h", ri, out_last[0][0], out_flit[0][0], ri == 19, d[ri]);
                else passed++;
            end
            in_valid[0][0] = wi < 20;
            in_flit[0][0] = wi < 20 ? d[wi] : '0;
            in_last[0][0] = wi == 19;
            tick();
            if (acc[0]) wi++;
            if (ev) ri++;
            cyc++;
        end
        in_valid[0][0] = 1'b0;
        in_last[0][0] = 1'b0;
        total++; if (ri != 20) $display("FAIL oversize_count got %0d expected 20", ri); else passed++;
        total++; if (err_oversize[0][0] !== 1'b1) $display("FAIL oversize_sticky got %b expected 1", err_oversize[0][0]); else passed++;
        total++; if (out_valid[0][0] !== 1'b0) $display("FAIL oversize_done got %b expected 0", out_valid[0][0]); else passed++;
    endtask

    task automatic test_simultaneous();
        int cnt = 0;
        do_reset();
        for (int j = 0; j < 5; j++) begin
            in_valid[0][0] = 1'b1;
            in_flit[0][0] = 32'hB0 + j;
            in_last[0][0] = j == 0;
            tick();
        end
        total++; if ({out_valid[0][0], out_last[0][0], out_flit[0][0]} !== {2'b11, 32'hB0}) $display("FAIL simul_head got v%b l%b %h expected v1 l1 b0", out_valid[0][0], out_last[0][0], out_flit[0][0]); else passed++;
        in_flit[0][0] = 32'hB5;
        in_last[0][0] = 1'b1;
        out_ready[0][0] = 1'b1;
        tick();
        out_ready[0][0] = 1'b0;
        in_last[0][0] = 1'b0;
        total++; if ({out_valid[0][0], out_last[0][0], out_flit[0][0]} !== {2'b10, 32'hB1}) $display("FAIL simul_after got v%b l%b %h expected v1 l0 b1", out_valid[0][0], out_last[0][0], out_flit[0][0]); else passed++;
        for (int j = 0; j < 20; j++) begin
            in_flit[0][0] = $urandom;
            tick();
            if (acc[0]) cnt++;
        end
        in_valid[0][0] = 1'b0;
        total++; if (cnt != 11) $display("FAIL simul_level got %0d free slots expected 11", cnt); else passed++;
        out_ready[0][0] = 1'b1;
        for (int j = 1; j < 6; j++) begin
            total++;
            if ({out_valid[0][0], out_last[0][0], out_flit[0][0]} !== {1'b1, j == 5, 32'hB0 + j})
                $display("FAIL simul_drain%0d got v%b l%b %h expected v1 l%b %h", j, out_valid[0][0], out_last[0][0], out_flit[0][0], j == 5, 32'hB0 + j);
            else passed++;
            tick();
        end
        total++; if (out_valid[0][0] !== 1'b0) $display("FAIL simul_pktcnt got %b expected 0", out_valid[0][0]); else passed++;
    endtask

    task automatic test_cut_through();
        do_reset();
        out_ready[1][0] = 1'b1;
        in_valid[1][1] = 1'b1;
        for (int j = 0; j < 16; j++) begin
            in_valid[1][0] = 1'b1;
            in_flit[1][0] = 32'h10 + j;
            in_last[1][0] = j % 4 == 3;
            in_flit[1][1] = $urandom;
            total++; if (in_ready[1][0] !== 1'b1) $display("FAIL ct_stall%0d got %b expected 1", j, in_ready[1][0]); else passed++;
            tick();
            total++;
            if ({out_valid[1][0], out_flit[1][0]} !== {1'b1, 32'h10 + j})
                $display("FAIL ct_data%0d got v%b %h expected v1 %h", j, out_valid[1][0], out_flit[1][0], 32'h10 + j);
            else passed++;
        end
        idle();
        total++; if (in_ready[1][1] !== 1'b0) $display("FAIL ct_ch1_full got %b expected 0", in_ready[1][1]); else passed++;
        total++; if (out_valid[1][1] !== 1'b1) $display("FAIL ct_ch1_valid got %b expected 1", out_valid[1][1]); else passed++;
        total++; if (err_oversize[1] !== 2'b00) $display("FAIL ct_err got %b expected 00", err_oversize[1]); else passed++;
        out_ready[1] = 2'b11;
        for (int j = 0; j < DEPTH + 1; j++) begin
            total++;
            if ({out_valid[1], out_flit[1]} !== {exp_ov(1), exp_of(1)})
                $display("FAIL ct_drain%0d got v%b %h expected v%b %h", j, out_valid[1], out_flit[1], exp_ov(1), exp_of(1));
            else passed++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int j = 0; j < DEPTH + 1; j++) begin
            in_valid[0][0] = j < 3;
            in_flit[0][0] = 32'hC0 + j;
            in_valid[0][1] = 1'b1;
            in_flit[0][1] = $urandom;
            tick();
        end
        idle();
        total++; if (out_valid[0][0] !== 1'b0) $display("FAIL areset_partial got %b expected 0", out_valid[0][0]); else passed++;
        total++; if (err_oversize[0][1] !== 1'b1) $display("FAIL areset_preerr got %b expected 1", err_oversize[0][1]); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid[0] !== 2'b00) $display("FAIL areset_valid got %b expected 00", out_valid[0]); else passed++;
        total++; if (in_ready[0] !== 2'b11) $display("FAIL areset_ready got %b expected 11", in_ready[0]); else passed++;
        total++; if (err_oversize[0] !== 2'b00) $display("FAIL areset_err got %b expected 00", err_oversize[0]); else passed++;
        total++; if (out_flit[0] !== '0) $display("FAIL areset_flit got %h expected 0", out_flit[0]); else passed++;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        out_ready[0][0] = 1'b1;
        for (int j = 0; j < 2; j++) begin
            in_valid[0][0] = 1'b1;
            in_flit[0][0] = 32'hD0 + j;
            in_last[0][0] = j == 1;
            tick();
        end
        in_valid[0][0] = 1'b0;
        in_last[0][0] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            total++;
            if ({out_valid[0][0], out_last[0][0], out_flit[0][0]} !== {1'b1, j == 1, 32'hD0 + j})
                $display("FAIL areset_new%0d got v%b l%b %h expected v1 l%b %h", j, out_valid[0][0], out_last[0][0], out_flit[0][0], j == 1, 32'hD0 + j);
            else passed++;
            tick();
        end
        total++; if (out_valid[0][0] !== 1'b0) $display("FAIL areset_newdone got %b expected 0", out_valid[0][0]); else passed++;
    endtask

    task automatic test_random();
        int last_div, rdy_pct;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            last_div = n < 400 ? 5 : 40;
            rdy_pct = n < 400 ? 60 : 25;
            for (int i = 0; i < 2; i++) begin
                total++;
                if ({out_valid[i], out_last[i], in_ready[i], err_oversize[i]} !== {exp_ov(i), exp_ol(i), exp_ir(i), exp_err(i)})
                    $display("FAIL rand_ctrl[%0d] cyc%0d got v%b l%b r%b e%b expected v%b l%b r%b e%b", i, n,
                             out_valid[i], out_last[i], in_ready[i], err_oversize[i], exp_ov(i), exp_ol(i), exp_ir(i), exp_err(i));
                else passed++;
                total++;
                if (out_flit[i] !== exp_of(i))
                    $display("FAIL rand_flit[%0d] cyc%0d got %h expected %h", i, n, out_flit[i], exp_of(i));
                else passed++;
                for (int c = 0; c < CH; c++) begin
                    in_valid[i][c] = $urandom_range(3) != 0;
                    in_last[i][c] = $urandom_range(last_div - 1) == 0;
                    in_flit[i][c] = $urandom;
                    out_ready[i][c] = $urandom_range(99) < rdy_pct;
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        m_reset();
        test_reset();
        test_packet_basic();
        test_full_backpressure();
        test_oversize();
        test_simultaneous();
        test_cut_through();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
